// File: rtl/demux8_collect_pkg.sv
// Shared definitions for the demux8_collect receive path: slot geometry,
// the all-slots-written mask value, output-stage state encoding and the
// 2-to-4 one-hot helper the slot decoder is built from.
package demux8_collect_pkg;

  localparam int unsigned SLOTS     = 8;
  localparam int unsigned SLOT_W    = 3;
  localparam logic [7:0]  MASK_FULL = 8'hFF;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // One half of the decoder tree: 2-bit select to 4-bit one-hot, gated by en.
  function automatic logic [3:0] demux4(input logic en, input logic [1:0] sel);
    demux4 = en ? (4'b0001 << sel) : 4'b0000;
  endfunction

endpackage

// File: rtl/demux8_dec.sv
// Combinational 3-to-8 one-hot slot decoder with enable.
// Built as two 4-way halves, the MSB of the select choosing which half is
// enabled, mirroring the transmit-side mux tree.
// Ports:
//   i_en     - decoder enable; all outputs low when 0
//   i_sel    - slot index
//   o_onehot - one-hot slot strobe
module demux8_dec
  import demux8_collect_pkg::*;
(
  input  logic              i_en,
  input  logic [SLOT_W-1:0] i_sel,
  output logic [SLOTS-1:0]  o_onehot
);

  logic       w_en_lo;
  logic       w_en_hi;
  logic [3:0] w_lo;
  logic [3:0] w_hi;

  assign w_en_lo  = i_en & ~i_sel[2];
  assign w_en_hi  = i_en &  i_sel[2];
  assign w_lo     = demux4(w_en_lo, i_sel[1:0]);
  assign w_hi     = demux4(w_en_hi, i_sel[1:0]);
  assign o_onehot = {w_hi, w_lo};

endmodule

// File: rtl/demux8_collect.sv
// Sequential 1-to-8 demultiplexer / deserializer. Serial bits are steered
// into an 8-slot assembly register either by a wrapping counter or by an
// explicit slot address; a completed byte is presented on a held,
// valid/ready output register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   i, i_valid- serial data bit and its qualifier
//   sync      - frame marker: restart counter, discard partial word
//   s_mode, s - 0: counter steering, 1: steer to slot s
//   o, o_valid, o_ready - completed word handshake
//   busy      - a partial word is being assembled
//   overrun   - sticky: a completed word was dropped while output was full
module demux8_collect
  import demux8_collect_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i,
  input  logic              i_valid,
  input  logic              sync,
  input  logic              s_mode,
  input  logic [SLOT_W-1:0] s,
  output logic [SLOTS-1:0]  o,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              busy,
  output logic              overrun
);

  logic [SLOTS-1:0]  r_asm;
  logic [SLOTS-1:0]  r_mask;
  logic [SLOT_W-1:0] r_cnt;
  logic [SLOTS-1:0]  r_o;
  logic              r_busy;
  logic              r_overrun;
  out_state_t        r_state;
  out_state_t        w_state_nxt;

  logic [SLOT_W-1:0] w_cnt_base;
  logic [SLOTS-1:0]  w_mask_base;
  logic [SLOT_W-1:0] w_slot;
  logic [SLOTS-1:0]  w_strobe;
  logic [SLOTS-1:0]  w_mask_upd;
  logic [SLOTS-1:0]  w_word;
  logic              w_complete;
  logic              w_load;
  logic              w_ovr_set;

  // sync clears the frame before the same-cycle bit is placed, so the
  // bit lands in a fresh mask at counter slot 0.
  assign w_cnt_base  = sync ? '0 : r_cnt;
  assign w_mask_base = sync ? '0 : r_mask;

  assign w_slot = s_mode    ? s :
                  LSB_FIRST ? w_cnt_base :
                              (SLOT_W'(SLOTS - 1) - w_cnt_base);

  demux8_dec u_dec (
    .i_en     (i_valid),
    .i_sel    (w_slot),
    .o_onehot (w_strobe)
  );

  assign w_mask_upd = w_mask_base | w_strobe;
  assign w_word     = (r_asm & ~w_strobe) | (w_strobe & {SLOTS{i}});
  assign w_complete = i_valid & (w_mask_upd == MASK_FULL);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (w_complete) begin
          w_load      = 1'b1;
          w_state_nxt = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (o_ready) begin
          if (w_complete) w_load = 1'b1;
          else            w_state_nxt = OUT_EMPTY;
        end else if (w_complete) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_state_nxt = OUT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= OUT_EMPTY;
      r_asm     <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_o       <= '0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_asm   <= w_word;
      if (w_complete) begin
        r_mask <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_mask <= w_mask_upd;
        r_cnt  <= (i_valid && !s_mode) ? w_cnt_base + 1'b1 : w_cnt_base;
        r_busy <= |w_mask_upd;
      end
      if (w_load)    r_o       <= w_word;
      if (w_ovr_set) r_overrun <= 1'b1;
    end
  end

  assign o       = r_o;
  assign o_valid = (r_state == OUT_FULL);
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_demux8_collect.sv
module tb_demux8_collect;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i = 1'b0;
  logic       i_valid = 1'b0;
  logic       sync = 1'b0;
  logic       s_mode = 1'b0;
  logic [2:0] s = 3'd0;
  logic [7:0] o;
  logic       o_valid;
  logic       o_ready = 1'b0;
  logic       busy;
  logic       overrun;

  always #5 clk = ~clk;

  demux8_collect #(.LSB_FIRST(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i       (i),
    .i_valid (i_valid),
    .sync    (sync),
    .s_mode  (s_mode),
    .s       (s),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy),
    .overrun (overrun)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: per-slot value and written flag, a frame counter,
  // and the output register as "holding a word or not".
  bit         m_val [8];
  bit         m_set [8];
  int         m_cnt = 0;
  bit         m_full = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    foreach (m_set[k]) if (m_set[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge(input bit r, input bit b, input bit iv, input bit sy,
                            input bit sm, input int sa, input bit rdy);
    int idx, n;
    bit done;
    logic [7:0] word;
    if (r) begin
      foreach (m_set[k]) begin m_set[k] = 0; m_val[k] = 0; end
      m_cnt = 0; m_full = 0; m_ovr = 0;
      exp_q.delete();
      return;
    end
    done = 0;
    if (sy) begin
      foreach (m_set[k]) m_set[k] = 0;
      m_cnt = 0;
    end
    if (iv) begin
      idx = sm ? sa : m_cnt;            // LSB_FIRST=1: counter slot k is bit k
      m_val[idx] = b;
      m_set[idx] = 1;
      if (!sm) m_cnt = (m_cnt + 1) % 8;
      n = 0;
      foreach (m_set[k]) n += int'(m_set[k]);
      if (n == 8) begin
        for (int k = 0; k < 8; k++) word[k] = m_val[k];
        foreach (m_set[k]) m_set[k] = 0;
        m_cnt = 0;
        done = 1;
      end
    end
    if (m_full && rdy) m_full = 0;
    if (done) begin
      if (m_full) m_ovr = 1;
      else begin
        m_full = 1;
        exp_q.push_back(word);
      end
    end
  endtask

  task automatic step(input bit r, input bit b, input bit iv, input bit sy,
                      input bit sm, input int sa, input bit rdy);
    rst = r; i = b; i_valid = iv; sync = sy; s_mode = sm; s = 3'(sa); o_ready = rdy;
    @(posedge clk);
    model_edge(r, b, iv, sy, sm, sa, rdy);
    mon_en = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send_seq(input logic [7:0] v, input bit rdy);
    for (int k = 0; k < 8; k++) step(0, v[k], 1, 0, 0, 0, rdy);
  endtask

  // Scoreboard monitor: checks status against the model every cycle and
  // pops the expected word whenever the DUT hands one over.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("o_valid", 32'(o_valid), 32'(m_full));
      chk("busy", 32'(busy), 32'(m_busy()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("word_unexpected", 32'(o), 32'hFFFF_FFFF);
        end else begin
          chk("word", 32'(o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // Reset with random inputs on the other lines
    for (int c = 0; c < 2; c++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 7)), 1'($urandom));
    chk("rst_o", 32'(o), 32'h0);
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // Sequential byte, busy through bits 1..7
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] pat;
      pat = 8'h4D;
      step(0, pat[k], 1, 0, 0, 0, 1);
      if (k < 7) chk("seq_busy", 32'(busy), 32'h1);
    end
    chk("seq_o", 32'(o), 32'h4D);
    chk("seq_valid", 32'(o_valid), 32'h1);
    chk("seq_busy_done", 32'(busy), 32'h0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("seq_drained", 32'(o_valid), 32'h0);

    // Backpressure
    do_reset();
    send_seq(8'h4D, 0);
    send_seq(8'hA5, 0);
    chk("bp_o_held", 32'(o), 32'h4D);
    chk("bp_overrun", 32'(overrun), 32'h1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bp_valid_low", 32'(o_valid), 32'h0);
    chk("bp_overrun_sticky", 32'(overrun), 32'h1);
    chk("bp_o_kept", 32'(o), 32'h4D);

    // Sync mid-word
    do_reset();
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, (k == 6), 1, 0, 0, 0, 0);
    chk("sync_o", 32'(o), 32'h81);
    chk("sync_valid", 32'(o_valid), 32'h1);
    chk("sync_no_ovr", 32'(overrun), 32'h0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("sync_one_word", 32'(o_valid), 32'h0);

    // Addressed mode
    do_reset();
    for (int sl = 7; sl >= 1; sl--) step(0, 1, 1, 0, 1, sl, 0);
    step(0, 0, 1, 0, 1, 3, 0);
    chk("addr_no_early", 32'(o_valid), 32'h0);
    step(0, 1, 1, 0, 1, 0, 0);
    chk("addr_o", 32'(o), 32'hF7);
    chk("addr_valid", 32'(o_valid), 32'h1);
    step(0, 0, 0, 0, 0, 0, 1);

    // Accept-and-refill
    do_reset();
    send_seq(8'h3C, 0);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] pat;
      pat = 8'hC6;
      step(0, pat[k], 1, 0, 0, 0, (k == 7));
    end
    chk("refill_valid", 32'(o_valid), 32'h1);
    chk("refill_o", 32'(o), 32'hC6);
    chk("refill_ovr", 32'(overrun), 32'h0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 299) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("final_queue", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
